display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter PRESCALE, default 4, ON-time per digit in clock cycles, legal range 1..65535.
REQ-002 Parameter BLANK_CYCLES, default 1, dead-time between digits in cycles, legal range 0..255; 0 means no dead-time.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port wr_en  input  1  write strobe for one digit register.
REQ-006 Port wr_addr  input  2  digit index written (0 = rightmost).
REQ-007 Port wr_data  input  4  hex value 0x0..0xF for digit wr_addr.
REQ-008 Port wr_dp  input  1  decimal-point bit for digit wr_addr.
REQ-009 Port display_on  input  1  1 = scan active; 0 = force blank.
REQ-010 Port lzb  input  1  1 = leading-zero blanking enabled.
REQ-011 Port seg  output  7  segment drive, active-high; seg[0]=a (top), [1]=b (upper right), [2]=c (lower right), [3]=d (bottom), [4]=e (lower left), [5]=f (upper left), [6]=g (middle).
REQ-012 Port dp  output  1  decimal-point drive, active-high.
REQ-013 Port digit_en  output  4  one-hot digit select, active-high; 0000 = none.
REQ-014 Port frame_done  output  1  one-cycle pulse at end of each full 4-digit scan.

Function
REQ-015 The block SHALL hold 4 digit registers (4-bit value + dp bit), written on the rising edge where wr_en=1; no write when wr_en=0.
REQ-016 The block SHALL implement FSM states BLANK and ON, with a digit index idx (2 bits, wraps 3->0) and a cycle counter.
REQ-017 In ON, digit_en SHALL be one-hot at bit idx, and seg/dp SHALL show the decoded register idx; ON SHALL last exactly PRESCALE cycles.
REQ-018 After ON ends: if BLANK_CYCLES>0, go to BLANK for exactly BLANK_CYCLES cycles, then ON with idx+1; if BLANK_CYCLES=0, go directly to ON with idx+1.
REQ-019 In BLANK, digit_en, seg and dp SHALL all be 0.
REQ-020 All outputs SHALL be registered: they reflect FSM state and register contents as of the preceding edge.
REQ-021 Hex decode SHALL be the standard pattern, given as seg[6:0] (g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-022 A write to the currently displayed digit SHALL appear on seg/dp on the cycle after the write edge, with no change to scan timing.
REQ-023 With lzb=1, digit k (k=3..1) SHALL be blanked (seg=0, dp still driven, digit_en still asserted) when its value and all higher digit values are 0; digit 0 is never blanked.
REQ-024 frame_done SHALL be 1 for exactly one cycle, on the cycle after the last ON cycle of idx=3.
REQ-025 display_on=0 SHALL force the FSM to BLANK, with idx=3 and counter cleared, on the next edge. Scanning SHALL resume at idx=0 after BLANK_CYCLES cycles, or on the next cycle if BLANK_CYCLES=0.
REQ-026 Simultaneous write and scan advance: the write SHALL be applied, and a digit entering ON on that edge SHALL show the new value one cycle later.

Reset
REQ-027 rst=1 SHALL set: all digit registers to 0, all dp bits to 0, state BLANK, idx=3, counter=0, seg=0, dp=0, digit_en=0000, frame_done=0.
REQ-028 rst SHALL take priority over wr_en and display_on; rst asserted mid-scan SHALL abort on the same edge.
REQ-029 After reset release with display_on=1, the first ON SHALL be idx=0, entered after BLANK_CYCLES cycles.

Verification
REQ-030 Defaults, display_on=1, lzb=0, digits 3..0 = 1,2,3,4 -> digit_en sequence: 0001 for 4 cycles (seg=1100110), then 0000 for 1 cycle, then 0010 for 4 cycles (seg=1001111), and so on; frame_done pulses every 20 cycles.
REQ-031 lzb=1, digits 3..0 = 0,0,7,0 -> during idx 3 and 2, seg=0000000; idx1 seg=0000111; idx0 seg=0111111.
REQ-032 Write 0xE to digit 0 mid-ON of idx 0 -> seg changes to 1111001 on the next cycle; ON still totals 4 cycles.
REQ-033 display_on dropped for 3 cycles during idx 2, then raised -> outputs 0 from the next edge; resume at idx 0 after 1 BLANK cycle.
REQ-034 BLANK_CYCLES=0, PRESCALE=1 -> digit_en rotates 0001, 0010, 0100, 1000 on consecutive cycles; frame_done pulses every 4 cycles.
REQ-035 rst asserted during idx 1 ON -> next cycle all outputs 0 and registers cleared; after release, 1 BLANK cycle then idx 0 ON showing seg=0111111.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit, 7-segment hex display.
//   The block holds four digit registers, each a 4-bit hex value plus a
//   decimal-point bit. It lights one digit at a time for PRESCALE cycles.
//   Between digits it inserts BLANK_CYCLES cycles of dead-time.
//
// Parameters
//   PRESCALE      ON-time per digit in clock cycles (1..65535)
//   BLANK_CYCLES  dead-time between digits in cycles (0..255, 0 = none)
//
// Ports
//   clk         clock, rising-edge active
//   rst         synchronous active-high reset
//   wr_en       write strobe for digit register wr_addr
//   wr_addr     digit index written (0 = rightmost)
//   wr_data     hex value for that digit
//   wr_dp       decimal-point bit for that digit
//   display_on  1 = scan active, 0 = force blank
//   lzb         1 = leading-zero blanking enabled
//   seg         segment drive, active-high, seg[0]=a .. seg[6]=g
//   dp          decimal-point drive, active-high
//   digit_en    one-hot digit select, active-high
//   frame_done  one-cycle pulse after the last ON cycle of digit 3
module display_scan_ctrl #(
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       display_on,
  input  logic       lzb,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] digit_en,
  output logic       frame_done
);

  typedef enum logic {
    ST_BLANK,
    ST_ON
  } state_t;

  localparam logic [15:0] ON_LAST    = 16'(PRESCALE - 1);
  localparam logic [15:0] BLANK_LAST = (BLANK_CYCLES == 0) ? 16'd0 : 16'(BLANK_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;

  logic [3:0]  val_q [4];
  logic [3:0]  dp_q;

  logic [3:0]  zero;
  logic        lz_blank;
  logic [3:0]  cur_val;
  logic [6:0]  seg_d;
  logic        dp_d;
  logic [3:0]  digit_en_d;
  logic        frame_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'b0111111;
      4'h1: hex_to_seg = 7'b0000110;
      4'h2: hex_to_seg = 7'b1011011;
      4'h3: hex_to_seg = 7'b1001111;
      4'h4: hex_to_seg = 7'b1100110;
      4'h5: hex_to_seg = 7'b1101101;
      4'h6: hex_to_seg = 7'b1111101;
      4'h7: hex_to_seg = 7'b0000111;
      4'h8: hex_to_seg = 7'b1111111;
      4'h9: hex_to_seg = 7'b1101111;
      4'hA: hex_to_seg = 7'b1110111;
      4'hB: hex_to_seg = 7'b1111100;
      4'hC: hex_to_seg = 7'b0111001;
      4'hD: hex_to_seg = 7'b1011110;
      4'hE: hex_to_seg = 7'b1111001;
      default: hex_to_seg = 7'b1110001;
    endcase
  endfunction

  // Scan sequencer. idx advances on entry to ON when there is dead-time, or
  // directly at the end of ON when there is none. This lets reset and
  // display_on=0 park idx at 3 so the scan always restarts at digit 0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 16'd1;
    if (!display_on) begin
      state_d = ST_BLANK;
      idx_d   = 2'd3;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ON: begin
          if (cnt_q == ON_LAST) begin
            cnt_d = '0;
            if (BLANK_CYCLES == 0) begin
              idx_d = idx_q + 2'd1;
            end else begin
              state_d = ST_BLANK;
            end
          end
        end
        default: begin
          if ((BLANK_CYCLES == 0) || (cnt_q == BLANK_LAST)) begin
            state_d = ST_ON;
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  // Leading-zero blanking: digit k is dark when it and every digit above it
  // hold zero. Digit 0 is always shown.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      zero[i] = (val_q[i] == 4'h0);
    end
    case (idx_q)
      2'd1:    lz_blank = lzb & zero[3] & zero[2] & zero[1];
      2'd2:    lz_blank = lzb & zero[3] & zero[2];
      2'd3:    lz_blank = lzb & zero[3];
      default: lz_blank = 1'b0;
    endcase
  end

  // Output values are computed from the current state and registers. They
  // are captured at the next edge, so the outputs lag the state by one
  // cycle. display_on gates them so that blanking takes effect on the very
  // next edge.
  always_comb begin
    digit_en_d = '0;
    seg_d      = '0;
    dp_d       = 1'b0;
    frame_d    = 1'b0;
    cur_val    = val_q[idx_q];
    if (display_on && (state_q == ST_ON)) begin
      digit_en_d = 4'b0001 << idx_q;
      seg_d      = lz_blank ? 7'b0000000 : hex_to_seg(cur_val);
      dp_d       = dp_q[idx_q];
      frame_d    = (idx_q == 2'd3) && (cnt_q == ON_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BLANK;
      idx_q      <= 2'd3;
      cnt_q      <= '0;
      dp_q       <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        val_q[i] <= '0;
      end
      seg        <= '0;
      dp         <= 1'b0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      if (wr_en) begin
        val_q[wr_addr] <= wr_data;
        dp_q[wr_addr]  <= wr_dp;
      end
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      seg        <= seg_d;
      dp         <= dp_d;
      digit_en   <= digit_en_d;
      frame_done <= frame_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic       wr_en, wr_dp;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       display_on, on2, lzb;
  logic [6:0] seg, seg2;
  logic       dp, dp2;
  logic [3:0] digit_en, digit_en2;
  logic       frame_done, frame_done2;
  logic [12:0] obs;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.PRESCALE(4), .BLANK_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dp(wr_dp), .display_on(display_on), .lzb(lzb), .seg(seg), .dp(dp),
    .digit_en(digit_en), .frame_done(frame_done)
  );

  display_scan_ctrl #(.PRESCALE(1), .BLANK_CYCLES(0)) u_fast (
    .clk(clk), .rst(rst2), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dp(wr_dp), .display_on(on2), .lzb(1'b0), .seg(seg2), .dp(dp2),
    .digit_en(digit_en2), .frame_done(frame_done2)
  );

  assign obs = {digit_en, seg, dp, frame_done};

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: seg_of = 7'b0111111;  4'h1: seg_of = 7'b0000110;
      4'h2: seg_of = 7'b1011011;  4'h3: seg_of = 7'b1001111;
      4'h4: seg_of = 7'b1100110;  4'h5: seg_of = 7'b1101101;
      4'h6: seg_of = 7'b1111101;  4'h7: seg_of = 7'b0000111;
      4'h8: seg_of = 7'b1111111;  4'h9: seg_of = 7'b1101111;
      4'hA: seg_of = 7'b1110111;  4'hB: seg_of = 7'b1111100;
      4'hC: seg_of = 7'b0111001;  4'hD: seg_of = 7'b1011110;
      4'hE: seg_of = 7'b1111001;  default: seg_of = 7'b1110001;
    endcase
  endfunction

  // Expected {digit_en, seg, dp, frame_done} n edges after display_on rises
  // from a parked (BLANK, idx 3) state, for PRESCALE=4, BLANK_CYCLES=1.
  // The first edge enters ON, and the outputs follow one edge later. Each
  // digit then spans 5 output cycles: 4 ON and 1 dark.
  function automatic logic [12:0] exp_vec(input int n, input logic [15:0] vals,
                                          input logic [3:0] dps, input logic lz);
    int t, ph, d;
    logic [3:0] v;
    logic blank, fd;
    t = n - 2;
    if (t < 0) return '0;
    ph = t % 5;
    d  = (t / 5) % 4;
    if (ph == 4) return '0;
    v     = vals[4*d +: 4];
    blank = lz && (d != 0) && ((vals >> (4*d)) == 16'h0);
    fd    = ((t % 20) == 18);
    return {4'(4'b0001 << d), blank ? 7'b0000000 : seg_of(v), dps[d], fd};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [3:0] d, input logic p);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = p;
    step;
    wr_en = 1'b0; wr_data = 4'hF; wr_dp = 1'b1;
  endtask

  task automatic park;
    display_on = 1'b0;
    step;
  endtask

  task automatic test_reset;
    logic [12:0] e;
    rst = 1'b1; rst2 = 1'b1; display_on = 1'b0; on2 = 1'b0; lzb = 1'b0;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'h0; wr_dp = 1'b0;
    step; step;
    n_cmp++;
    if (obs !== 13'h0) begin
      n_bad++; $display("FAIL reset_main got %b want %b", obs, 13'h0);
    end
    n_cmp++;
    if ({digit_en2, seg2, dp2, frame_done2} !== 13'h0) begin
      n_bad++; $display("FAIL reset_fast got %b want 0", {digit_en2, seg2, dp2, frame_done2});
    end
    rst = 1'b0; rst2 = 1'b0; display_on = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step;
      e = exp_vec(n, 16'h0000, 4'b0000, 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL reset_release n=%0d got %b want %b", n, obs, e);
      end
    end
  endtask

  task automatic test_scan;
    logic [12:0] e;
    park;
    do_write(2'd0, 4'h4, 1'b0);
    do_write(2'd1, 4'h3, 1'b1);
    do_write(2'd2, 4'h2, 1'b0);
    do_write(2'd3, 4'h1, 1'b0);
    n_cmp++;
    if (obs !== 13'h0) begin
      n_bad++; $display("FAIL scan_parked got %b want 0", obs);
    end
    display_on = 1'b1;
    for (int n = 1; n <= 42; n++) begin
      step;
      e = exp_vec(n, 16'h1234, 4'b0010, 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL scan n=%0d got %b want %b", n, obs, e);
      end
    end
  endtask

  task automatic test_write_mid;
    logic [12:0] e;
    park;
    display_on = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      if (n == 3) begin
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'hE; wr_dp = 1'b0;
      end
      step;
      wr_en = 1'b0;
      e = exp_vec(n, (n >= 4) ? 16'h123E : 16'h1234, 4'b0010, 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL write_mid n=%0d got %b want %b", n, obs, e);
      end
    end
  endtask

  task automatic test_write_on_advance;
    logic [12:0] e;
    park;
    display_on = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      // This write lands on the same edge that moves digit 1 into ON.
      if (n == 6) begin
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h9; wr_dp = 1'b0;
      end
      step;
      wr_en = 1'b0;
      e = (n >= 7) ? exp_vec(n, 16'h129E, 4'b0000, 1'b0)
                   : exp_vec(n, 16'h123E, 4'b0010, 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL write_advance n=%0d got %b want %b", n, obs, e);
      end
    end
  endtask

  task automatic test_lzb;
    logic [12:0] e;
    park;
    do_write(2'd3, 4'h0, 1'b0);
    do_write(2'd2, 4'h0, 1'b0);
    do_write(2'd1, 4'h7, 1'b0);
    do_write(2'd0, 4'h0, 1'b0);
    lzb = 1'b1;
    display_on = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      step;
      e = exp_vec(n, 16'h0070, 4'b0000, 1'b1);
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL lzb n=%0d got %b want %b", n, obs, e);
      end
    end
    lzb = 1'b0;
  endtask

  task automatic test_display_off;
    logic [12:0] e;
    park;
    display_on = 1'b1;
    for (int n = 1; n <= 27; n++) begin
      if (n == 14) display_on = 1'b0;
      if (n == 17) display_on = 1'b1;
      step;
      if (n <= 13)      e = exp_vec(n, 16'h0070, 4'b0000, 1'b0);
      else if (n <= 16) e = '0;
      else              e = exp_vec(n - 16, 16'h0070, 4'b0000, 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL display_off n=%0d got %b want %b", n, obs, e);
      end
    end
  endtask

  task automatic test_rst_mid;
    logic [12:0] e;
    park;
    display_on = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      // Reset during digit 1 ON, with a competing write that must be ignored.
      if (n == 9) begin
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h5; wr_dp = 1'b1;
      end
      step;
      rst = 1'b0; wr_en = 1'b0;
      if (n <= 8)      e = exp_vec(n, 16'h0070, 4'b0000, 1'b0);
      else if (n == 9) e = '0;
      else             e = exp_vec(n - 9, 16'h0000, 4'b0000, 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL rst_mid n=%0d got %b want %b", n, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [12:0] e2, o2;
    int d;
    on2 = 1'b0;
    step;
    on2 = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      step;
      // The fast unit also saw the write made during the main unit's reset.
      if (n == 1) begin
        e2 = '0;
      end else begin
        d  = (n - 2) % 4;
        e2 = {4'(4'b0001 << d), (d == 1) ? seg_of(4'h5) : seg_of(4'h0),
              (d == 1), (d == 3)};
      end
      o2 = {digit_en2, seg2, dp2, frame_done2};
      n_cmp++;
      if (o2 !== e2) begin
        n_bad++; $display("FAIL back_to_back n=%0d got %b want %b", n, o2, e2);
      end
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_write_mid;
    test_write_on_advance;
    test_lzb;
    test_display_off;
    test_rst_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
